// File: rtl/axiom_apb_requester.sv
// APB4 requester: converts a valid/ready command stream into APB transfers, one response each.
// Optional ACCESS-phase timeout is built when AXIOM_APB_REQUESTER_TIMEOUT_EN is defined.
module axiom_apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pwstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  input  logic                    pready
);

  if (!(DATA_WIDTH inside {8, 16, 32}) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axiom_apb_requester: DATA_WIDTH must be 8/16/32 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   timeout_hit;
  logic   access_done;

  assign cmd_ready   = (state == IDLE);
  assign psel        = (state == SETUP) || (state == ACCESS);
  assign penable     = (state == ACCESS);
  assign rsp_valid   = (state == RESP);
  assign access_done = (state == ACCESS) && (pready || timeout_hit);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pwstrb    <= '0;
      pprot     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
        pwstrb <= cmd_write ? cmd_wstrb : '0;
        pprot  <= cmd_prot;
      end
      // A timeout (pready low) yields zero data with the error flag forced.
      if (access_done) begin
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
        pwrite    <= 1'b0;
      end
    end
  end

`ifdef AXIOM_APB_REQUESTER_TIMEOUT_EN
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 timeout_q;

  // The limit is hit on the cycle the count would reach TIMEOUT_CYCLES, so pready wins a tie.
  assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == CNT_LIMIT);
  assign rsp_timeout = timeout_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !pready && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (access_done) timeout_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axiom_apb_requester.sv
// Scoreboard bench for axiom_apb_requester: directed cases plus randomized traffic
// against a transaction-level model; a completer model and a response monitor do the checking.
module tb_axiom_apb_requester;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pwstrb;
  logic [2:0]    pprot;
  logic          pslverr, pready;

  axiom_apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pwstrb(pwstrb), .pprot(pprot), .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [2:0]    prot;
    int            waits;
    logic [DW-1:0] prdata;
    logic          slverr;
  } txn_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  txn_t apb_q[$];
  rsp_t rsp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rsp_stall = 1'b0;
  bit   random_bp = 1'b0;
  bit   abort_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not expected or never seen at %0t", name, $time);
  endtask

  function automatic bit times_out(input txn_t t);
`ifdef AXIOM_APB_REQUESTER_TIMEOUT_EN
    return t.waits >= TMO;
`else
    return 1'b0;
`endif
  endfunction

  // Number of cycles penable should be seen high for this transfer.
  function automatic int exp_access(input txn_t t);
    return times_out(t) ? TMO : t.waits + 1;
  endfunction

  function automatic rsp_t model_rsp(input txn_t t);
    rsp_t r;
    if (times_out(t)) begin
      r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1;
    end else begin
      r.rdata = t.write ? '0 : t.prdata; r.err = t.slverr; r.tmo = 1'b0;
    end
    return r;
  endfunction

  function automatic txn_t mk(input logic [AW-1:0] addr, input logic write, input logic [DW-1:0] wdata,
                              input logic [SW-1:0] wstrb, input logic [2:0] prot, input int waits,
                              input logic [DW-1:0] rd, input logic err);
    txn_t t;
    t.addr = addr; t.write = write; t.wdata = wdata; t.wstrb = wstrb; t.prot = prot;
    t.waits = waits; t.prdata = rd; t.slverr = err;
    return t;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input txn_t t);
    bit ok = 1'b0;
    cmd_addr = t.addr; cmd_write = t.write; cmd_wdata = t.wdata;
    cmd_wstrb = t.wstrb; cmd_prot = t.prot; cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge pclk);
    end
    if (ok) begin
      apb_q.push_back(t);
      rsp_q.push_back(model_rsp(t));
    end else begin
      fail("cmd_accept_timeout");
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_q.size() == 0 && apb_q.size() == 0 && cmd_ready) begin ok = 1'b1; break; end
      @(negedge pclk);
    end
    if (!ok) fail("drain_timeout");
  endtask

  // APB completer model: inserts the requested wait states and checks the APB side.
  initial begin
    txn_t cur;
    bit   active = 1'b0;
    int   acc = 0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (psel && !penable) begin
        if (apb_q.size() == 0) begin
          fail("apb_unexpected_setup");
        end else begin
          cur = apb_q.pop_front();
          check("setup_paddr", paddr, cur.addr);
          check("setup_pwdata", pwdata, cur.wdata);
          check("setup_ctrl", {pprot, pwstrb, pwrite}, {cur.prot, cur.write ? cur.wstrb : '0, cur.write});
          active = 1'b1;
          acc = 0;
        end
        pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end else if (psel && penable) begin
        check("access_stable", {paddr, pwdata}, {cur.addr, cur.wdata});
        check("access_ctrl", {pprot, pwstrb, pwrite}, {cur.prot, cur.write ? cur.wstrb : '0, cur.write});
        acc++;
        if (acc == cur.waits + 1) begin
          pready = 1'b1; prdata = cur.prdata; pslverr = cur.slverr;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        end
      end else begin
        if (active) begin
          if (abort_pending) abort_pending = 1'b0;
          else check("access_cycles", acc, exp_access(cur));
          active = 1'b0;
        end
        pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: compares every presented response cycle against the scoreboard head.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset || !rsp_valid) begin
        rsp_ready = 1'b0;
      end else if (rsp_q.size() == 0) begin
        fail("rsp_unexpected");
        rsp_ready = 1'b1;
      end else begin
        check("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
        check("rsp_flags", {rsp_err, rsp_timeout}, {rsp_q[0].err, rsp_q[0].tmo});
        check("resp_apb_idle", {psel, penable, pwrite, cmd_ready}, 4'b0000);
        rsp_ready = !rsp_stall && (!random_bp || $urandom_range(0, 3) != 0);
        if (rsp_ready) void'(rsp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    txn_t t;
    preset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_wstrb = '0; cmd_prot = '0;
    repeat (3) @(negedge pclk);
    check("reset_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 6'b0);
    check("reset_paddr", paddr, 0);
    check("reset_data", {pwdata, rsp_rdata}, 0);
    check("reset_strb_prot", {pwstrb, pprot}, 0);
    preset = 1'b0;
    check("reset_cmd_ready", cmd_ready, 1);

    // Zero-wait write with latency measurement.
    issue(mk(32'h40, 1'b1, 32'hA5A5_0001, 4'hF, 3'h2, 0, 32'h1357_9BDF, 1'b0));
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge pclk); n++; end
    check("write_latency", n, 3);
    wait_idle();

    // Read with three wait states; strobes ignored on reads.
    issue(mk(32'h100, 1'b0, 32'h0, 4'hF, 3'h0, 3, 32'hDEAD_BEEF, 1'b0));
    wait_idle();

    // Slave error on write, then a clean read.
    issue(mk(32'h200, 1'b1, 32'h1111_2222, 4'h3, 3'h1, 1, 32'h0, 1'b1));
    issue(mk(32'h204, 1'b0, 32'h0, 4'h0, 3'h5, 0, 32'hCAFE_F00D, 1'b0));
    wait_idle();
    issue(mk(32'h208, 1'b0, 32'h0, 4'h0, 3'h7, 2, 32'hBAD0_0BAD, 1'b1));
    wait_idle();

    // Response backpressure with the next command already waiting.
    rsp_stall = 1'b1;
    issue(mk(32'h300, 1'b0, 32'h0, 4'h0, 3'h0, 1, 32'h0F0F_0F0F, 1'b0));
    fork
      issue(mk(32'h304, 1'b1, 32'h7777_8888, 4'hC, 3'h4, 0, 32'h0, 1'b0));
      begin
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge pclk); n++; end
        check("bp_rsp_seen", rsp_valid, 1);
        repeat (5) begin
          check("bp_hold", {cmd_ready, psel, rsp_valid}, 3'b001);
          @(negedge pclk);
        end
        rsp_stall = 1'b0;
      end
    join
    wait_idle();

    // Reset in the middle of ACCESS with pready low.
    issue(mk(32'h400, 1'b0, 32'h0, 4'h0, 3'h0, 20, 32'h0, 1'b0));
    repeat (2) @(negedge pclk);
    check("pre_reset_access", {psel, penable}, 2'b11);
    abort_pending = 1'b1;
    preset = 1'b1;
    @(negedge pclk);
    check("mid_reset_outputs", {psel, penable, rsp_valid, pwrite, cmd_ready}, 5'b00001);
    preset = 1'b0;
    rsp_q.delete();
    @(negedge pclk);
    check("post_reset_ready", {cmd_ready, psel}, 2'b10);

`ifdef AXIOM_APB_REQUESTER_TIMEOUT_EN
    issue(mk(32'h500, 1'b1, 32'h5555_AAAA, 4'hF, 3'h3, 10, 32'h0, 1'b0));
    wait_idle();
    issue(mk(32'h504, 1'b0, 32'h0, 4'h0, 3'h0, TMO - 1, 32'h1234_5678, 1'b0));
    wait_idle();
    issue(mk(32'h508, 1'b0, 32'h0, 4'h0, 3'h0, TMO, 32'h8765_4321, 1'b0));
    wait_idle();
`endif

    // Randomized traffic with random response backpressure.
    random_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      t = mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             3'($urandom_range(0, 7)), 0, $urandom, 1'($urandom_range(0, 3) == 0));
`ifdef AXIOM_APB_REQUESTER_TIMEOUT_EN
      t.waits = $urandom_range(0, TMO + 2);
`else
      t.waits = $urandom_range(0, 5);
`endif
      issue(t);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
